hazard_unit: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage RV32I core. Decodes the IF/ID

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_src_decode.sv | 21 ++
 rtl/hazard_unit.sv | 111 +++++++++++
 tb/tb_hazard_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode classes, NOP encoding, forwarding select and hazard FSM types
package hazard_pkg;
  localparam logic [4:0] OPC_LUI = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_JAL = 5'b11011;
  localparam logic [4:0] OPC_OP = 5'b01100;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int FC_W = 3;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} hz_state_t;
endpackage

// File: rtl/hazard_src_decode.sv
// hazard_src_decode: extracts rs1/rs2 from an RV32I instruction and flags which sources are really read
module hazard_src_decode
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instruction,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic              rs1_used,
  output logic              rs2_used
);
  logic [4:0] opc;
  logic unused_bits;
  assign opc = instruction[6:2];
  assign rs1 = instruction[15 +: REG_AW];
  assign rs2 = instruction[20 +: REG_AW];
  assign rs1_used = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign rs2_used = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  assign unused_bits = ^{instruction[31:25], instruction[14:7], instruction[1:0]};
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, EX forwarding, redirect flush and mem-busy freeze; HAZARD_STATS_EN adds stall_count/flush_count
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_id_instruction,
  input  logic [REG_AW-1:0] id_ex_rs1,
  input  logic [REG_AW-1:0] id_ex_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              ex_mem_regwrite,
  input  logic              mem_wb_regwrite,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              holdpc,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);
  localparam logic [FC_W-1:0] RELOAD = FC_W'(FLUSH_CYCLES - 1);
  hz_state_t state, state_n;
  logic [FC_W-1:0] cnt, cnt_n;
  logic [REG_AW-1:0] rs1, rs2;
  logic rs1_used, rs2_used, load_use, hold, flush, bubble;
  fwd_sel_t sel_a, sel_b;
  hazard_src_decode #(.REG_AW(REG_AW)) u_dec (
    .instruction(if_id_instruction),
    .rs1(rs1),
    .rs2(rs2),
    .rs1_used(rs1_used),
    .rs2_used(rs2_used)
  );
  assign load_use = id_ex_memread && id_ex_rd != '0 &&
                    ((rs1_used && rs1 == id_ex_rd) || (rs2_used && rs2 == id_ex_rd));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hold = 1'b0;
    flush = 1'b0;
    bubble = 1'b0;
    if (mem_busy) begin
      hold = 1'b1;
      state_n = MEM_WAIT;
    end else if (ex_redirect) begin
      flush = 1'b1;
      bubble = 1'b1;
      cnt_n = RELOAD;
      state_n = RELOAD != '0 ? FLUSH : RUN;
    end else if (state != RUN && cnt != '0) begin
      flush = 1'b1;
      bubble = 1'b1;
      cnt_n = cnt - FC_W'(1);
      state_n = cnt == FC_W'(1) ? RUN : FLUSH;
    end else begin
      hold = load_use;
      bubble = load_use;
      state_n = RUN;
    end
  end
  always_comb begin
    sel_a = rst ? FWD_RF :
            (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == id_ex_rs1) ? FWD_MEM :
            (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == id_ex_rs1) ? FWD_WB : FWD_RF;
    sel_b = rst ? FWD_RF :
            (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == id_ex_rs2) ? FWD_MEM :
            (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == id_ex_rs2) ? FWD_WB : FWD_RF;
  end
  assign fwd_a = sel_a;
  assign fwd_b = sel_b;
  assign holdpc = !rst && hold;
  assign if_id_hold = !rst && hold;
  assign if_id_flush = !rst && flush;
  assign id_ex_bubble = !rst && bubble;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (holdpc && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (if_id_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit with FLUSH_CYCLES=3, CNT_W=4
module tb_hazard_unit;
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] ADD_651 = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD_600 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI_6 = {12'h000, 5'd5, 3'd0, 5'd6, 7'b0110111};
  localparam logic [31:0] ADDI_615 = {12'd5, 5'd1, 3'd0, 5'd6, 7'b0010011};
  localparam logic [31:0] SW_51 = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
  logic clk = 1'b0;
  logic rst;
  logic [31:0] instr;
  logic [4:0] id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic id_ex_memread, ex_mem_regwrite, mem_wb_regwrite, ex_redirect, mem_busy;
  logic holdpc, if_id_hold, if_id_flush, id_ex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] ctl;
  int errors = 0;
  int checks = 0;
`ifdef HAZARD_STATS_EN
  logic [3:0] stall_count, flush_count;
`endif
  always #5 clk = ~clk;
  assign ctl = {holdpc, if_id_hold, if_id_flush, id_ex_bubble};
  hazard_unit #(.REG_AW(5), .FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .if_id_instruction(instr),
    .id_ex_rs1(id_ex_rs1),
    .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd),
    .mem_wb_rd(mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_regwrite(mem_wb_regwrite),
    .ex_redirect(ex_redirect),
    .mem_busy(mem_busy),
    .holdpc(holdpc),
    .if_id_hold(if_id_hold),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count(stall_count),
    .flush_count(flush_count)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    rst = 1'b0;
    instr = NOP_I;
    {id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
    {id_ex_memread, ex_mem_regwrite, mem_wb_regwrite, ex_redirect, mem_busy} = '0;
  endtask
  task automatic drive(input logic [3:0] s);
    idle();
    rst = s[3];
    ex_redirect = s[2];
    mem_busy = s[1];
    if (s[0]) begin
      instr = ADD_651;
      id_ex_memread = 1'b1;
      id_ex_rd = 5'd5;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    mem_busy = 1'b1;
    ex_redirect = 1'b1;
    ex_mem_regwrite = 1'b1;
    ex_mem_rd = 5'd3;
    id_ex_rs1 = 5'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== 4'b0000) begin errors++; $display("FAIL reset_ctl[%0d]: got %b want 0000", i, ctl); end
      checks++;
      if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a[%0d]: got %b want 00", i, fwd_a); end
      tick();
    end
    idle();
    tick();
  endtask
  task automatic test_load_use;
    logic [31:0] vi[7] = '{ADD_651, ADD_651, ADD_600, LUI_6, ADDI_615, SW_51, ADD_651};
    logic vld[7] = '{1, 0, 1, 1, 1, 1, 1};
    logic [4:0] vrd[7] = '{5, 5, 0, 5, 5, 5, 1};
    logic [3:0] ve[7] = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b1101};
    for (int i = 0; i < 7; i++) begin
      idle();
      instr = vi[i];
      id_ex_memread = vld[i];
      id_ex_rd = vrd[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin errors++; $display("FAIL load_use[%0d]: got %b want %b", i, ctl, ve[i]); end
      tick();
    end
    idle();
    tick();
  endtask
  task automatic test_forward;
    logic vxw[5] = '{1, 0, 1, 1, 1};
    logic [4:0] vxr[5] = '{3, 3, 0, 7, 3};
    logic vww[5] = '{1, 1, 1, 1, 0};
    logic [4:0] vwr[5] = '{3, 3, 0, 8, 4};
    logic [4:0] v1[5] = '{3, 3, 0, 8, 4};
    logic [4:0] v2[5] = '{4, 3, 0, 7, 3};
    logic [1:0] ea[5] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00};
    logic [1:0] eb[5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 5; i++) begin
      idle();
      ex_mem_regwrite = vxw[i];
      ex_mem_rd = vxr[i];
      mem_wb_regwrite = vww[i];
      mem_wb_rd = vwr[i];
      id_ex_rs1 = v1[i];
      id_ex_rs2 = v2[i];
      #1;
      checks++;
      if (fwd_a !== ea[i]) begin errors++; $display("FAIL fwd_a[%0d]: got %b want %b", i, fwd_a, ea[i]); end
      checks++;
      if (fwd_b !== eb[i]) begin errors++; $display("FAIL fwd_b[%0d]: got %b want %b", i, fwd_b, eb[i]); end
      tick();
    end
    idle();
  endtask
  task automatic run_seq(input string name, input int n, input logic [3:0] s[10], input logic [3:0] e[10]);
    for (int i = 0; i < n; i++) begin
      drive(s[i]);
      #1;
      checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL %s[%0d]: got %b want %b", name, i, ctl, e[i]); end
      tick();
    end
    idle();
    tick();
  endtask
  task automatic test_redirect;
    int flushes = 0;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0 ? 4'b0100 : 4'b0000);
      #1;
      flushes += int'(if_id_flush);
      checks++;
      if (ctl !== (i < 3 ? 4'b0011 : 4'b0000)) begin errors++; $display("FAIL redirect[%0d]: got %b", i, ctl); end
      tick();
    end
    checks++;
    if (flushes !== 3) begin errors++; $display("FAIL redirect_len: got %0d want 3", flushes); end
  endtask
  task automatic test_mem_in_flush;
    run_seq("mem_in_flush", 8,
      '{4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{4'b0011, 4'b0011, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0011, 4'b0000, 4'b0000, 4'b0000});
  endtask
  task automatic test_mem_run;
    run_seq("mem_run", 6,
      '{4'b0110, 4'b0110, 4'b0000, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{4'b1100, 4'b1100, 4'b0000, 4'b1100, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
  endtask
  task automatic test_priority;
    run_seq("priority", 5,
      '{4'b0101, 4'b0001, 4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
  endtask
  task automatic test_back_to_back;
    run_seq("back_to_back", 5,
      '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
  endtask
`ifdef HAZARD_STATS_EN
  task automatic test_stats;
    drive(4'b1000);
    tick();
    checks++;
    if (stall_count !== 4'd0) begin errors++; $display("FAIL stats_reset: got %0d want 0", stall_count); end
    for (int i = 0; i < 20; i++) begin
      drive(4'b0001);
      tick();
    end
    checks++;
    if (stall_count !== 4'd15) begin errors++; $display("FAIL stall_sat: got %0d want 15", stall_count); end
    drive(4'b0100);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      tick();
    end
    checks++;
    if (flush_count !== 4'd3) begin errors++; $display("FAIL flush_count: got %0d want 3", flush_count); end
  endtask
`endif
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_redirect();
    test_mem_in_flush();
    test_mem_run();
    test_priority();
    test_back_to_back();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
